ocp_fault_manager: RTL

- Supervisory controller on the consuming side of the per-rail OCP detectors: reacts to their latched OCP_RESULT flags and drives their OCP_CLEAR and EN inputs.
- Owns rail enables: power-up with inrush blanking, fast shutdown on overcurrent, timed clear/cooldown, bounded auto-retry, then lockout until host acknowledge.
- Sits between the host power-sequencing registers and the NUM_CH detector instances.

---
 rtl/ocp_pkg.sv | 27 ++
 rtl/ocp_fault_manager_if.sv | 28 ++
 rtl/ocp_timer.sv | 24 ++
 rtl/ocp_fault_manager.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ocp_pkg.sv
// Shared types and defaults for the OCP fault manager and its timer.
package ocp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBlank,
        StRun,
        StClear,
        StCool,
        StLockout
    } ocp_state_e;

    localparam int unsigned NUM_CH_DEF     = 4;
    localparam int unsigned CNT_W_DEF      = 24;
    localparam int unsigned BLANK_CYC_DEF  = 1000;
    localparam int unsigned CLR_CYC_DEF    = 4;
    localparam int unsigned COOL_CYC_DEF   = 10000000;
    localparam int unsigned STABLE_CYC_DEF = 5000000;
    localparam int unsigned MAX_RETRY_DEF  = 3;
    localparam int unsigned RETRY_W        = 3;

    // True when a cycle count is non-zero and representable in a w-bit timer.
    function automatic bit cyc_ok(longint unsigned cyc, int unsigned w);
        return (cyc >= 1) && (cyc < (64'd1 << w));
    endfunction

endpackage

// File: rtl/ocp_fault_manager_if.sv
// Host and detector signals of the OCP fault manager, grouped as one bundle.
interface ocp_fault_manager_if
    import ocp_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
);
    logic               PWR_ON;
    logic               FAULT_ACK;
    logic [NUM_CH-1:0]  OCP_RESULT;
    logic               OCP_EN;
    logic [NUM_CH-1:0]  OCP_CLEAR;
    logic [NUM_CH-1:0]  RAIL_EN;
    logic [NUM_CH-1:0]  FAULT_CH;
    logic [RETRY_W-1:0] RETRY_CNT;
    logic               LOCKOUT;
    logic               BUSY;

    modport master (
        output PWR_ON, FAULT_ACK, OCP_RESULT,
        input  OCP_EN, OCP_CLEAR, RAIL_EN, FAULT_CH, RETRY_CNT, LOCKOUT, BUSY
    );

    modport slave (
        input  PWR_ON, FAULT_ACK, OCP_RESULT,
        output OCP_EN, OCP_CLEAR, RAIL_EN, FAULT_CH, RETRY_CNT, LOCKOUT, BUSY
    );

endinterface

// File: rtl/ocp_timer.sv
// Clearable up-counter with a terminal-compare flag; clear has priority over count.
module ocp_timer #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         hit
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign hit = (cnt_q == term);

endmodule

// File: rtl/ocp_fault_manager.sv
// Rail supervisor: inrush blanking, fast trip, timed clear/cooldown, bounded retry, lockout.
module ocp_fault_manager
    import ocp_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned BLANK_CYC  = BLANK_CYC_DEF,
    parameter int unsigned CLR_CYC    = CLR_CYC_DEF,
    parameter int unsigned COOL_CYC   = COOL_CYC_DEF,
    parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF,
    parameter int unsigned STABLE_CYC = STABLE_CYC_DEF
) (
    input logic               CLK_10MHz,
    input logic               RESET,
    ocp_fault_manager_if.slave bus
);
    if (!cyc_ok(BLANK_CYC, CNT_W) || !cyc_ok(CLR_CYC, CNT_W) ||
        !cyc_ok(COOL_CYC, CNT_W) || !cyc_ok(STABLE_CYC, CNT_W)) begin : g_bad_cyc
        $error("ocp_fault_manager: cycle parameter out of range for CNT_W");
    end
    if (MAX_RETRY >= (1 << RETRY_W)) begin : g_bad_retry
        $error("ocp_fault_manager: MAX_RETRY does not fit RETRY_W");
    end

    ocp_state_e         state_q, state_d;
    logic [NUM_CH-1:0]  rail_en_q, rail_en_d;
    logic [NUM_CH-1:0]  ocp_clear_q, ocp_clear_d;
    logic [NUM_CH-1:0]  fault_ch_q, fault_ch_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               ocp_en_q, ocp_en_d;
    logic               lockout_q, lockout_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   phase_term;
    logic               phase_hit, stable_hit, fault, stable_inc;

    assign fault      = |bus.OCP_RESULT;
    assign stable_inc = (state_q == StRun) && !fault;

    always_comb begin
        case (state_q)
            StBlank: phase_term = CNT_W'(BLANK_CYC - 1);
            StClear: phase_term = CNT_W'(CLR_CYC - 1);
            default: phase_term = CNT_W'(COOL_CYC - 1);
        endcase
    end

    // Restarts on every state change so each phase measures from its own entry edge.
    ocp_timer #(.W(CNT_W)) u_phase_timer (
        .clk  (CLK_10MHz),
        .rst  (RESET),
        .clr  (state_d != state_q),
        .en   (state_q inside {StBlank, StClear, StCool}),
        .term (phase_term),
        .hit  (phase_hit)
    );

    // Parks at STABLE_CYC-1; the fault-free edge that would reach STABLE_CYC clears retries.
    ocp_timer #(.W(CNT_W)) u_stable_timer (
        .clk  (CLK_10MHz),
        .rst  (RESET),
        .clr  (state_q != StRun),
        .en   (stable_inc && !stable_hit),
        .term (CNT_W'(STABLE_CYC - 1)),
        .hit  (stable_hit)
    );

    always_comb begin
        state_d    = state_q;
        fault_ch_d = fault_ch_q;
        retry_d    = retry_q;
        case (state_q)
            StIdle: begin
                if (bus.PWR_ON) begin
                    state_d    = StBlank;
                    fault_ch_d = '0;
                end
            end
            StBlank: begin
                if (!bus.PWR_ON) state_d = StIdle;
                else if (phase_hit) state_d = StRun;
            end
            StRun: begin
                if (fault) begin
                    state_d    = StClear;
                    fault_ch_d = bus.OCP_RESULT;
                end else if (!bus.PWR_ON) begin
                    state_d = StIdle;
                end
                if (stable_inc && stable_hit) retry_d = '0;
            end
            StClear: begin
                if (phase_hit) state_d = StCool;
            end
            StCool: begin
                if (phase_hit) begin
                    if (!bus.PWR_ON) begin
                        state_d = StIdle;
                        retry_d = '0;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        state_d = StBlank;
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = StLockout;
                    end
                end
            end
            StLockout: begin
                if (bus.FAULT_ACK && !bus.PWR_ON) begin
                    state_d    = StIdle;
                    retry_d    = '0;
                    fault_ch_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs are a pure function of the state being entered.
        rail_en_d   = (state_d inside {StBlank, StRun}) ? '1 : '0;
        ocp_clear_d = (state_d == StClear) ? '1 : '0;
        ocp_en_d    = (state_d == StRun);
        lockout_d   = (state_d == StLockout);
        busy_d      = (state_d inside {StBlank, StClear, StCool, StLockout});
    end

    always_ff @(posedge CLK_10MHz) begin
        if (RESET) begin
            state_q     <= StIdle;
            rail_en_q   <= '0;
            ocp_clear_q <= '0;
            fault_ch_q  <= '0;
            retry_q     <= '0;
            ocp_en_q    <= 1'b0;
            lockout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rail_en_q   <= rail_en_d;
            ocp_clear_q <= ocp_clear_d;
            fault_ch_q  <= fault_ch_d;
            retry_q     <= retry_d;
            ocp_en_q    <= ocp_en_d;
            lockout_q   <= lockout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.RAIL_EN   = rail_en_q;
    assign bus.OCP_CLEAR = ocp_clear_q;
    assign bus.FAULT_CH  = fault_ch_q;
    assign bus.RETRY_CNT = retry_q;
    assign bus.OCP_EN    = ocp_en_q;
    assign bus.LOCKOUT   = lockout_q;
    assign bus.BUSY      = busy_q;

endmodule
